mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported unified memory between the instruction-fetch stage and the
//  data-memory stage of the pipelined MIPS core. Arbitrates requests, drives the memory
//  handshake, and turns the 2-bit memwrite code (sw/sh/sb) into byte enables and
//  lane-replicated write data. Sits between the pipeline and the memory, below top.
// PARAMETERS
//  STARVE_LIMIT  4   cycles i_req may lose to d_req before fetch is forced to win (>=1)
//  CNT_W         3   width of starvation counter; must hold STARVE_LIMIT
// PORTS
//  clk         in   1   core clock, rising edge
//  reset       in   1   asynchronous, active-high reset
//  i_req       in   1   fetch request; held with i_addr until i_valid
//  i_addr      in   32  fetch byte address (word aligned)
//  i_rdata     out  32  fetched word, valid with i_valid
//  i_valid     out  1   one-cycle completion pulse for fetch
//  d_req       in   1   data request; held with d_* until d_valid
//  d_memwrite  in   2   00 load, 01 sw, 10 sh, 11 sb
//  d_addr      in   32  data byte address
//  d_wdata     in   32  store data, right-justified for sh/sb
//  d_rdata     out  32  loaded word (full word; extraction done by pipeline)
//  d_valid     out  1   one-cycle completion pulse for data
//  d_misalign  out  1   one-cycle pulse, misaligned access rejected (MEM_ARB_MISALIGN_TRAP_EN only)
//  m_req       out  1   memory request, held until m_ack
//  m_we        out  1   1 = write
//  m_be        out  4   byte enables, bit n = byte lane n (little-endian)
//  m_addr      out  32  word address {addr[31:2],2'b00}
//  m_wdata     out  32  lane-replicated write data
//  m_rdata     in   32  memory read data, valid with m_ack
//  m_ack       in   1   memory completion; may be asserted in first m_req cycle
// BEHAVIOUR
//  - FSM IDLE -> SERVE_I | SERVE_D -> DONE -> IDLE. All outputs registered.
//  - IDLE: if d_req and (i_req=0 or starve_cnt<STARVE_LIMIT) -> SERVE_D; else if i_req -> SERVE_I.
//    Both asserted: data wins unless starve_cnt==STARVE_LIMIT, then fetch wins.
//  - Entering SERVE_x: latch address/code/data, assert m_req, m_we, m_be, m_addr, m_wdata.
//  - SERVE_x: stay while m_ack=0 (m_* stable); on m_ack -> DONE, capture m_rdata into
//    x_rdata, drop m_req, pulse x_valid for exactly the DONE cycle.
//  - DONE -> IDLE unconditionally; blocks re-grant of a requester still holding req.
//  - Min latency: req seen at edge0, i_valid/d_valid high in cycle after edge1 (zero-wait ack);
//    next grant earliest at edge3.
//  - Lanes: load be=1111 we=0; sw be=1111 wdata as-is; sh be=addr[1]?1100:0011,
//    wdata={2{d_wdata[15:0]}}; sb be=4'b0001<<addr[1:0], wdata={4{d_wdata[7:0]}}.
//  - starve_cnt: +1 on each IDLE arbitration where i_req=1 and D granted, saturates at
//    STARVE_LIMIT; cleared on SERVE_I grant. Unchanged otherwise.
//  - i_rdata/d_rdata hold last captured value until next completion for that port.
//  - Reset (any state, incl. mid-transaction): state IDLE, starve_cnt 0, all outputs 0;
//    in-flight memory access abandoned, late m_ack ignored in IDLE.
//  - m_ack while not in SERVE_x is ignored.
// CONFIGURATION
//  MEM_ARB_MISALIGN_TRAP_EN defined: sw with addr[1:0]!=0 or sh with addr[0]=1 is not
//   issued; FSM IDLE -> DONE with d_misalign=1 and d_valid=1 in DONE, no m_req, d_rdata kept.
//  Undefined: d_misalign tied 0; misaligned sw uses be=1111, sh uses addr[1] only (addr[0]
//   ignored); access issued normally.
// STRUCTURE
//  mem_arb_pkg: memwrite_t enum (MW_LOAD/MW_WORD/MW_HALF/MW_BYTE), arb_state_t enum,
//   function calc_be(memwrite_t, logic[1:0] addr).
//  Sub-module mem_lane_align: combinational be + wdata replication (+ misalign flag).
// TESTING
//  1 reset=1 22ns then 0, i_req addr 0x0, ack 1 cycle later, m_rdata 0x20020005 -> m_we=0,
//    m_be=1111, i_valid one cycle, i_rdata=0x20020005.
//  2 d_req sh addr 80 wdata 0x0000FFFF -> m_addr 80, m_be 0011, m_wdata 0xFFFFFFFF, m_we=1;
//    addr 82 -> m_be 1100.
//  3 d_req sb addr 0x53 wdata 0xAB -> m_be 1000, m_wdata 0xABABABAB.
//  4 i_req and d_req held high continuously, zero-wait ack -> D granted 4 times, then I,
//    pattern repeats; no double-serve after any valid.
//  5 reset asserted in SERVE_D with m_ack low -> next cycle m_req=0, d_valid=0, state IDLE;
//    later ack ignored.
//  6 TRAP_EN: sh addr 81 -> no m_req, d_misalign=d_valid=1 for one cycle; without macro:
//    m_be 0011 issued.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified-memory port arbiter.
// Optional feature macro used by this slice: MEM_ARB_MISALIGN_TRAP_EN.
package mem_arb_pkg;

  // Store width code carried down the pipeline (sw/sh/sb).
  typedef enum logic [1:0] {
    MW_LOAD = 2'b00,
    MW_WORD = 2'b01,
    MW_HALF = 2'b10,
    MW_BYTE = 2'b11
  } memwrite_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SERVE_I,
    ST_SERVE_D,
    ST_DONE
  } arb_state_t;

  localparam logic [3:0] BE_ALL = 4'b1111;

  // Byte enables for a given width code and byte offset (little-endian lanes).
  // Halfword placement looks only at addr[1]; addr[0] does not move the lanes.
  function automatic logic [3:0] calc_be(input memwrite_t mw, input logic [1:0] addr);
    logic [3:0] be;
    be = BE_ALL;
    case (mw)
      MW_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
      MW_BYTE: be = 4'b0001 << addr;
      default: be = BE_ALL;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering for data accesses: byte enables, replicated
// write data, and (with MEM_ARB_MISALIGN_TRAP_EN) a misaligned-access flag.
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  memwrite_t   i_mw,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misalign
);

  // Replicate right-justified store data into every lane so the memory only needs be.
  always_comb begin
    o_be    = calc_be(i_mw, i_addr_lo);
    o_wdata = i_wdata;
    case (i_mw)
      MW_HALF: o_wdata = {2{i_wdata[15:0]}};
      MW_BYTE: o_wdata = {4{i_wdata[7:0]}};
      default: o_wdata = i_wdata;
    endcase
`ifdef MEM_ARB_MISALIGN_TRAP_EN
    o_misalign = ((i_mw == MW_WORD) && (i_addr_lo != 2'b00)) ||
                 ((i_mw == MW_HALF) && i_addr_lo[0]);
`else
    o_misalign = 1'b0;
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one single-ported memory.
// Data normally wins; a starvation counter forces fetch through after
// STARVE_LIMIT consecutive losses. All outputs come straight from registers.
// Optional feature: MEM_ARB_MISALIGN_TRAP_EN rejects misaligned sw/sh without
// touching memory and reports them on d_misalign.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_valid,
  input  logic        d_req,
  input  logic [1:0]  d_memwrite,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        d_misalign,
  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack
);

  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STARVE_LIMIT);
  localparam logic [31:0]      WORD_MSK = 32'hFFFF_FFFC;

  arb_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_m_req, w_m_req_nxt;
  logic             r_m_we, w_m_we_nxt;
  logic [3:0]       r_m_be, w_m_be_nxt;
  logic [31:0]      r_m_addr, w_m_addr_nxt;
  logic [31:0]      r_m_wdata, w_m_wdata_nxt;
  logic [31:0]      r_i_rdata, w_i_rdata_nxt;
  logic             r_i_valid, w_i_valid_nxt;
  logic [31:0]      r_d_rdata, w_d_rdata_nxt;
  logic             r_d_valid, w_d_valid_nxt;
  logic             r_d_misalign, w_d_misalign_nxt;

  memwrite_t        w_mw;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic             w_misalign;
  logic             w_grant_d;

  // Saturating increment for the starvation counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= LIMIT) ? LIMIT : v + CNT_W'(1);
  endfunction

  assign w_mw = memwrite_t'(d_memwrite);

  mem_lane_align u_align (
    .i_mw       (w_mw),
    .i_addr_lo  (d_addr[1:0]),
    .i_wdata    (d_wdata),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_misalign (w_misalign)
  );

  // Data wins unless fetch has already lost STARVE_LIMIT arbitrations in a row.
  assign w_grant_d = d_req && (!i_req || (r_cnt < LIMIT));

  // Next-state and next-output logic; completion pulses default low.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_m_req_nxt      = r_m_req;
    w_m_we_nxt       = r_m_we;
    w_m_be_nxt       = r_m_be;
    w_m_addr_nxt     = r_m_addr;
    w_m_wdata_nxt    = r_m_wdata;
    w_i_rdata_nxt    = r_i_rdata;
    w_i_valid_nxt    = 1'b0;
    w_d_rdata_nxt    = r_d_rdata;
    w_d_valid_nxt    = 1'b0;
    w_d_misalign_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_d) begin
          if (i_req) w_cnt_nxt = sat_inc(r_cnt);
          if (w_misalign) begin
            // Rejected access: skip the memory and report it from DONE.
            w_state_nxt      = ST_DONE;
            w_d_valid_nxt    = 1'b1;
            w_d_misalign_nxt = 1'b1;
          end else begin
            w_state_nxt   = ST_SERVE_D;
            w_m_req_nxt   = 1'b1;
            w_m_we_nxt    = (w_mw != MW_LOAD);
            w_m_be_nxt    = w_be;
            w_m_addr_nxt  = d_addr & WORD_MSK;
            w_m_wdata_nxt = w_wdata;
          end
        end else if (i_req) begin
          w_state_nxt   = ST_SERVE_I;
          w_cnt_nxt     = '0;
          w_m_req_nxt   = 1'b1;
          w_m_we_nxt    = 1'b0;
          w_m_be_nxt    = BE_ALL;
          w_m_addr_nxt  = i_addr & WORD_MSK;
          w_m_wdata_nxt = 32'h0;
        end
      end
      ST_SERVE_I: begin
        if (m_ack) begin
          w_state_nxt   = ST_DONE;
          w_m_req_nxt   = 1'b0;
          w_i_rdata_nxt = m_rdata;
          w_i_valid_nxt = 1'b1;
        end
      end
      ST_SERVE_D: begin
        if (m_ack) begin
          w_state_nxt   = ST_DONE;
          w_m_req_nxt   = 1'b0;
          w_d_rdata_nxt = m_rdata;
          w_d_valid_nxt = 1'b1;
        end
      end
      default: begin
        // DONE: one dead cycle so a requester still holding req is not re-served.
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any in-flight access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_m_req      <= 1'b0;
      r_m_we       <= 1'b0;
      r_m_be       <= 4'b0000;
      r_m_addr     <= 32'h0;
      r_m_wdata    <= 32'h0;
      r_i_rdata    <= 32'h0;
      r_i_valid    <= 1'b0;
      r_d_rdata    <= 32'h0;
      r_d_valid    <= 1'b0;
      r_d_misalign <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_m_req      <= w_m_req_nxt;
      r_m_we       <= w_m_we_nxt;
      r_m_be       <= w_m_be_nxt;
      r_m_addr     <= w_m_addr_nxt;
      r_m_wdata    <= w_m_wdata_nxt;
      r_i_rdata    <= w_i_rdata_nxt;
      r_i_valid    <= w_i_valid_nxt;
      r_d_rdata    <= w_d_rdata_nxt;
      r_d_valid    <= w_d_valid_nxt;
      r_d_misalign <= w_d_misalign_nxt;
    end
  end

  assign m_req      = r_m_req;
  assign m_we       = r_m_we;
  assign m_be       = r_m_be;
  assign m_addr     = r_m_addr;
  assign m_wdata    = r_m_wdata;
  assign i_rdata    = r_i_rdata;
  assign i_valid    = r_i_valid;
  assign d_rdata    = r_d_rdata;
  assign d_valid    = r_d_valid;
  assign d_misalign = r_d_misalign;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a scoreboard of expected memory
// transactions and a small memory responder with programmable ack delay.
module tb_mem_port_arbiter;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_valid;
  logic        d_req;
  logic [1:0]  d_memwrite;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        d_misalign;
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack;

  logic        ack_en;
  logic        ack_force;
  int          ack_delay;
  int          wait_cnt;
  logic [31:0] mem_data;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];

  mem_port_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_valid    (i_valid),
    .d_req      (d_req),
    .d_memwrite (d_memwrite),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_valid    (d_valid),
    .d_misalign (d_misalign),
    .m_req      (m_req),
    .m_we       (m_we),
    .m_be       (m_be),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_rdata    (m_rdata),
    .m_ack      (m_ack)
  );

  always #5 clk = ~clk;

  // Memory responder: acks after ack_delay cycles of m_req, or on demand via ack_force.
  always @(posedge clk) begin
    if (!m_req || m_ack) wait_cnt <= 0;
    else                 wait_cnt <= wait_cnt + 1;
  end
  assign m_ack   = ack_force | (ack_en & m_req & (wait_cnt == ack_delay));
  assign m_rdata = mem_data;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One isolated request on one port, checked from grant through completion.
  task automatic do_single(input string tag, input logic is_d, input logic [1:0] mw,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int delay,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    exp_t e;
    int   n;
    e.is_d  = is_d;
    e.we    = is_d && (mw != 2'b00);
    e.be    = exp_be;
    e.addr  = addr & 32'hFFFF_FFFC;
    e.wdata = exp_wdata;
    e.rdata = rdata;
    sb_q.push_back(e);
    mem_data  = rdata;
    ack_delay = delay;
    if (is_d) begin
      d_memwrite = mw; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    end else begin
      i_addr = addr; i_req = 1'b1;
    end
    n = 0;
    while (m_req !== 1'b1 && n < 20) begin step(); n++; end
    chk1({tag, "_mreq"}, m_req, 1'b1);
    e = sb_q.pop_front();
    chk1({tag, "_we"}, m_we, e.we);
    chk32({tag, "_be"}, {28'h0, m_be}, {28'h0, e.be});
    chk32({tag, "_addr"}, m_addr, e.addr);
    if (e.we) chk32({tag, "_wdata"}, m_wdata, e.wdata);
    n = 0;
    while (((e.is_d ? d_valid : i_valid) !== 1'b1) && n < 20) begin step(); n++; end
    if (e.is_d) begin
      chk1({tag, "_dvalid"}, d_valid, 1'b1);
      chk1({tag, "_ivalid_quiet"}, i_valid, 1'b0);
      chk32({tag, "_drdata"}, d_rdata, e.rdata);
      chk1({tag, "_misalign"}, d_misalign, 1'b0);
    end else begin
      chk1({tag, "_ivalid"}, i_valid, 1'b1);
      chk1({tag, "_dvalid_quiet"}, d_valid, 1'b0);
      chk32({tag, "_irdata"}, i_rdata, e.rdata);
    end
    i_req = 1'b0;
    d_req = 1'b0;
    step();
    chk1({tag, "_valid_pulse"}, i_valid | d_valid, 1'b0);
    chk1({tag, "_mreq_drop"}, m_req, 1'b0);
    step();
  endtask

  initial begin
    exp_t e;
    int   n;
    logic seen_req;
    reset = 1'b1;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_memwrite = 2'b00; d_addr = 32'h0; d_wdata = 32'h0;
    ack_en = 1'b1; ack_force = 1'b0; ack_delay = 0; mem_data = 32'h0;
    #22;
    reset = 1'b0;
    step();
    chk1("rst_mreq", m_req, 1'b0);
    chk1("rst_ivalid", i_valid, 1'b0);
    chk1("rst_dvalid", d_valid, 1'b0);
    chk1("rst_misalign", d_misalign, 1'b0);
    chk32("rst_irdata", i_rdata, 32'h0);
    chk32("rst_mbe", {28'h0, m_be}, 32'h0);

    // Fetch with a one-cycle-late ack.
    do_single("t1_fetch", 1'b0, 2'b00, 32'h0, 32'h0, 32'h2002_0005, 1, 4'b1111, 32'h0);

    // Halfword, byte and word stores, then a load that must not disturb i_rdata.
    do_single("t2_sh80", 1'b1, 2'b10, 32'h80, 32'h0000_FFFF, 32'h0, 0, 4'b0011, 32'hFFFF_FFFF);
    do_single("t2_sh82", 1'b1, 2'b10, 32'h82, 32'h0000_FFFF, 32'h0, 0, 4'b1100, 32'hFFFF_FFFF);
    do_single("t3_sb53", 1'b1, 2'b11, 32'h53, 32'h0000_00AB, 32'h0, 0, 4'b1000, 32'hABAB_ABAB);
    do_single("t3_sw10", 1'b1, 2'b01, 32'h10, 32'hDEAD_BEEF, 32'h0, 2, 4'b1111, 32'hDEAD_BEEF);
    do_single("t3_lw44", 1'b1, 2'b00, 32'h44, 32'h0, 32'hCAFE_F00D, 0, 4'b1111, 32'h0);
    chk32("t3_irdata_held", i_rdata, 32'h2002_0005);

    // Both ports requesting continuously: four data grants, then one fetch, twice.
    ack_delay = 0;
    mem_data  = 32'h5555_AAAA;
    for (int k = 0; k < 10; k++) begin
      e.is_d = (k != 4) && (k != 9);
      e.we = 1'b0; e.be = 4'b1111; e.wdata = 32'h0; e.rdata = 32'h5555_AAAA;
      e.addr = e.is_d ? 32'h200 : 32'h100;
      sb_q.push_back(e);
    end
    i_addr = 32'h100; d_addr = 32'h200; d_memwrite = 2'b00;
    i_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      n = 0;
      while (m_req !== 1'b1 && n < 10) begin step(); n++; end
      chk1("t4_mreq", m_req, 1'b1);
      e = sb_q.pop_front();
      chk32("t4_grant_addr", m_addr, e.addr);
      n = 0;
      while ((i_valid | d_valid) !== 1'b1 && n < 10) begin step(); n++; end
      chk1("t4_dvalid", d_valid, e.is_d);
      chk1("t4_ivalid", i_valid, !e.is_d);
      if (k == 9) begin i_req = 1'b0; d_req = 1'b0; end
      step();
      chk1("t4_no_double_serve", m_req, 1'b0);
      chk1("t4_valid_pulse", i_valid | d_valid, 1'b0);
    end
    step();

    // Reset in the middle of a data access that the memory never acks.
    ack_en = 1'b0;
    e.is_d = 1'b1; e.we = 1'b0; e.be = 4'b1111; e.addr = 32'h40; e.wdata = 32'h0; e.rdata = 32'h0;
    sb_q.push_back(e);
    d_memwrite = 2'b00; d_addr = 32'h40; d_req = 1'b1;
    n = 0;
    while (m_req !== 1'b1 && n < 10) begin step(); n++; end
    e = sb_q.pop_front();
    chk32("t5_addr", m_addr, e.addr);
    step();
    chk1("t5_mreq_hold", m_req, 1'b1);
    chk1("t5_no_valid", d_valid, 1'b0);
    #2 reset = 1'b1;
    #1 chk1("t5_async_mreq", m_req, 1'b0);
    step();
    chk1("t5_rst_mreq", m_req, 1'b0);
    chk1("t5_rst_dvalid", d_valid, 1'b0);
    d_req = 1'b0;
    reset = 1'b0;
    ack_force = 1'b1;
    mem_data  = 32'hBAD0_BAD0;
    for (int k = 0; k < 2; k++) begin
      step();
      chk1("t5_late_ack_mreq", m_req, 1'b0);
      chk1("t5_late_ack_dvalid", d_valid, 1'b0);
      chk1("t5_late_ack_ivalid", i_valid, 1'b0);
      chk32("t5_late_ack_drdata", d_rdata, 32'h0);
    end
    ack_force = 1'b0;
    ack_en    = 1'b1;
    step();

    // Misaligned halfword store.
    do_single("t6_prime", 1'b1, 2'b00, 32'h60, 32'h0, 32'h1122_3344, 0, 4'b1111, 32'h0);
`ifdef MEM_ARB_MISALIGN_TRAP_EN
    d_memwrite = 2'b10; d_addr = 32'h81; d_wdata = 32'h0000_1234; d_req = 1'b1;
    seen_req = 1'b0;
    n = 0;
    while (d_valid !== 1'b1 && n < 10) begin
      step();
      if (m_req === 1'b1) seen_req = 1'b1;
      n++;
    end
    chk1("t6_trap_dvalid", d_valid, 1'b1);
    chk1("t6_trap_misalign", d_misalign, 1'b1);
    chk1("t6_trap_no_mreq", seen_req, 1'b0);
    chk32("t6_trap_drdata_kept", d_rdata, 32'h1122_3344);
    d_req = 1'b0;
    step();
    chk1("t6_trap_pulse", d_misalign, 1'b0);
    chk1("t6_trap_dvalid_pulse", d_valid, 1'b0);
    chk1("t6_trap_mreq_after", m_req, 1'b0);
    step();
`else
    seen_req = 1'b0;
    do_single("t6_sh81", 1'b1, 2'b10, 32'h81, 32'h0000_1234, 32'h0, 0, 4'b0011, 32'h1234_1234);
    do_single("t6_sw82", 1'b1, 2'b01, 32'h82, 32'h0BAD_CAFE, 32'h0, 0, 4'b1111, 32'h0BAD_CAFE);
    chk1("t6_no_misalign", d_misalign | seen_req, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
